// File: rtl/tlp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tlp_tx_arbiter
// Purpose  : Round-robin, packet-atomic merge of NUM_REQ TLP pipes onto the
//            single FPGA->Host pipe, registered through a 2-entry skid stage.
// Revision : 1.0
// ============================================================================
module tlp_tx_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic                      pcieClk_in,
    input  logic                      reset_in,
    input  logic [NUM_REQ-1:0][63:0]  reqData_in,
    input  logic [NUM_REQ-1:0]        reqSOP_in,
    input  logic [NUM_REQ-1:0]        reqEOP_in,
    input  logic [NUM_REQ-1:0]        reqValid_in,
    output logic [NUM_REQ-1:0]        reqReady_out,
    output logic [63:0]               txData_out,
    output logic                      txSOP_out,
    output logic                      txEOP_out,
    output logic                      txValid_out,
    input  logic                      txReady_in,
    output logic [REQ_W-1:0]          grant_out,
    output logic                      busy_out,
    output logic                      protoErr_out
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_stateNext;
    logic [REQ_W-1:0]   r_grant;
    logic [REQ_W-1:0]   w_grantNext;
    logic               r_firstBeat;
    logic               w_firstNext;
    logic               r_protoErr;
    logic               w_errNext;

    logic               w_hit;
    logic [REQ_W-1:0]   w_hitIdx;
    logic [REQ_W-1:0]   w_probe;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_reqReady;
    logic [63:0]        w_inData;
    logic               w_inSop;
    logic               w_inEop;

    // Output register O and skid register S
    logic               r_oValid;
    logic [63:0]        r_oData;
    logic               r_oSop;
    logic               r_oEop;
    logic               r_sValid;
    logic [63:0]        r_sData;
    logic               r_sSop;
    logic               r_sEop;

    always_comb begin
        w_stateNext = r_state;
        w_grantNext = r_grant;
        w_firstNext = r_firstBeat;
        w_errNext   = r_protoErr;
        w_hit       = 1'b0;
        w_hitIdx    = '0;
        w_probe     = '0;
        w_accept    = 1'b0;
        w_reqReady  = '0;
        w_inData    = reqData_in[r_grant];
        w_inSop     = reqSOP_in[r_grant];
        w_inEop     = reqEOP_in[r_grant];

        case (r_state)
            ST_IDLE: begin
                if (|(reqValid_in & ~reqSOP_in)) begin
                    w_errNext = 1'b1;
                end
                // Search starts just after the last grant, wrapping around
                for (int k = 1; k <= NUM_REQ; k++) begin
                    w_probe = REQ_W'((int'(r_grant) + k) % NUM_REQ);
                    if (!w_hit && reqValid_in[w_probe] && reqSOP_in[w_probe]) begin
                        w_hit    = 1'b1;
                        w_hitIdx = w_probe;
                    end
                end
                if (w_hit) begin
                    w_grantNext = w_hitIdx;
                    w_stateNext = ST_LOCKED;
                    w_firstNext = 1'b1;
                end
            end
            default: begin
                w_reqReady[r_grant] = ~r_sValid;
                w_accept = reqValid_in[r_grant] & ~r_sValid;
                if (w_accept) begin
                    w_firstNext = 1'b0;
                    if (w_inSop && !r_firstBeat) begin
                        w_errNext = 1'b1;
                    end
                    if (w_inEop) begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= ST_IDLE;
            r_grant     <= REQ_W'(NUM_REQ - 1);
            r_firstBeat <= 1'b0;
            r_protoErr  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_grant     <= w_grantNext;
            r_firstBeat <= w_firstNext;
            r_protoErr  <= w_errNext;
        end
    end

    // A beat is only accepted while S is empty, so S and a new beat never compete for O
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            r_oValid <= 1'b0;
            r_oData  <= '0;
            r_oSop   <= 1'b0;
            r_oEop   <= 1'b0;
            r_sValid <= 1'b0;
            r_sData  <= '0;
            r_sSop   <= 1'b0;
            r_sEop   <= 1'b0;
        end else if (!r_oValid || txReady_in) begin
            if (r_sValid) begin
                r_oValid <= 1'b1;
                r_oData  <= r_sData;
                r_oSop   <= r_sSop;
                r_oEop   <= r_sEop;
                r_sValid <= 1'b0;
                r_sData  <= '0;
                r_sSop   <= 1'b0;
                r_sEop   <= 1'b0;
            end else begin
                r_oValid <= w_accept;
                r_oData  <= w_accept ? w_inData : 64'd0;
                r_oSop   <= w_accept & w_inSop;
                r_oEop   <= w_accept & w_inEop;
            end
        end else if (w_accept) begin
            r_sValid <= 1'b1;
            r_sData  <= w_inData;
            r_sSop   <= w_inSop;
            r_sEop   <= w_inEop;
        end
    end

    assign reqReady_out = w_reqReady;
    assign txData_out   = r_oData;
    assign txSOP_out    = r_oSop;
    assign txEOP_out    = r_oEop;
    assign txValid_out  = r_oValid;
    assign grant_out    = r_grant;
    assign busy_out     = (r_state == ST_LOCKED);
    assign protoErr_out = r_protoErr;

endmodule
`default_nettype wire
